// File: rtl/instr_pkg.sv
// Shared MIPS encoding constants and request types for the program-loader encoder.
// The control decoder imports the same opcode and funct constants.
package instr_pkg;

  // 25 operations occupy 0..24; 25..31 are rejected as illegal
  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLL, OP_JR, OP_JALR,
    OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_BEQ, OP_BNE, OP_LUI,
    OP_J, OP_JAL, OP_ERET, OP_NOP, OP_LI
  } op_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0a;
  localparam logic [5:0] OPC_ANDI  = 6'h0c;
  localparam logic [5:0] OPC_ORI   = 6'h0d;
  localparam logic [5:0] OPC_XORI  = 6'h0e;
  localparam logic [5:0] OPC_LUI   = 6'h0f;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;

  localparam logic [31:0] WORD_ERET = 32'h4200_0018;
  localparam logic [31:0] WORD_NOP  = 32'h0000_0000;

  typedef struct packed {
    op_e         op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [31:0] imm;
    logic [25:0] target;
  } req_t;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
    return {OPC_RTYPE, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_word_build.sv
// Combinational assembly of one instruction word from a symbolic request.
// second_half selects the trailing ORI of a two-word LI expansion.
module instr_word_build
  import instr_pkg::*;
(
  input  req_t        req,
  input  logic        second_half,
  output logic [31:0] word,
  output logic        needs_second,
  output logic        illegal
);

  always_comb begin
    word         = WORD_NOP;
    needs_second = 1'b0;
    illegal      = 1'b0;
    case (req.op)
      OP_ADD:  word = r_word(req.rs, req.rt, req.rd, 5'd0, FN_ADD);
      OP_SUB:  word = r_word(req.rs, req.rt, req.rd, 5'd0, FN_SUB);
      OP_AND:  word = r_word(req.rs, req.rt, req.rd, 5'd0, FN_AND);
      OP_OR:   word = r_word(req.rs, req.rt, req.rd, 5'd0, FN_OR);
      OP_XOR:  word = r_word(req.rs, req.rt, req.rd, 5'd0, FN_XOR);
      OP_NOR:  word = r_word(req.rs, req.rt, req.rd, 5'd0, FN_NOR);
      OP_SLT:  word = r_word(req.rs, req.rt, req.rd, 5'd0, FN_SLT);
      OP_SLL:  word = r_word(5'd0, req.rt, req.rd, req.shamt, FN_SLL);
      OP_JR:   word = r_word(req.rs, 5'd0, 5'd0, 5'd0, FN_JR);
      OP_JALR: word = r_word(req.rs, 5'd0, req.rd, 5'd0, FN_JALR);
      OP_LW:   word = i_word(OPC_LW,   req.rs, req.rt, req.imm[15:0]);
      OP_SW:   word = i_word(OPC_SW,   req.rs, req.rt, req.imm[15:0]);
      OP_ADDI: word = i_word(OPC_ADDI, req.rs, req.rt, req.imm[15:0]);
      OP_ANDI: word = i_word(OPC_ANDI, req.rs, req.rt, req.imm[15:0]);
      OP_ORI:  word = i_word(OPC_ORI,  req.rs, req.rt, req.imm[15:0]);
      OP_XORI: word = i_word(OPC_XORI, req.rs, req.rt, req.imm[15:0]);
      OP_SLTI: word = i_word(OPC_SLTI, req.rs, req.rt, req.imm[15:0]);
      OP_BEQ:  word = i_word(OPC_BEQ,  req.rs, req.rt, req.imm[15:0]);
      OP_BNE:  word = i_word(OPC_BNE,  req.rs, req.rt, req.imm[15:0]);
      OP_LUI:  word = i_word(OPC_LUI,  5'd0,   req.rt, req.imm[15:0]);
      OP_J:    word = {OPC_J,   req.target};
      OP_JAL:  word = {OPC_JAL, req.target};
      OP_ERET: word = WORD_ERET;
      OP_NOP:  word = WORD_NOP;
      OP_LI: begin
        // Small constants fit one ORI from $0; otherwise LUI high then ORI low
        if (second_half)
          word = i_word(OPC_ORI, req.rt, req.rt, req.imm[15:0]);
        else if (req.imm[31:16] == 16'h0)
          word = i_word(OPC_ORI, 5'd0, req.rt, req.imm[15:0]);
        else begin
          word         = i_word(OPC_LUI, 5'd0, req.rt, req.imm[31:16]);
          needs_second = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: accepts symbolic requests and writes encoded MIPS words
// sequentially into instruction memory, expanding LI into one or two words.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_op,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_shamt,
  input  logic [31:0]       req_imm,
  input  logic [25:0]       req_target,
  input  logic              addr_clr,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              err,
  output logic              wrapped
);

  typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_e;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_e            state, state_nxt;
  req_t              in_req, lat_req, bld_req;
  logic [31:0]       bld_word;
  logic              bld_second, bld_illegal;
  logic              need2, accept, wr_done;
  logic [ADDR_W-1:0] addr;

  always_comb begin
    in_req.op     = op_e'(req_op);
    in_req.rs     = req_rs;
    in_req.rt     = req_rt;
    in_req.rd     = req_rd;
    in_req.shamt  = req_shamt;
    in_req.imm    = req_imm;
    in_req.target = req_target;
  end

  // One builder serves both the incoming request (IDLE) and the latched LI tail
  assign bld_req = (state == IDLE) ? in_req : lat_req;

  instr_word_build u_build (
    .req          (bld_req),
    .second_half  (state != IDLE),
    .word         (bld_word),
    .needs_second (bld_second),
    .illegal      (bld_illegal)
  );

  assign req_ready = (state == IDLE);
  assign mem_we    = (state != IDLE);
  assign mem_addr  = addr;
  assign accept    = req_ready && req_valid;
  assign wr_done   = mem_we && mem_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid && !bld_illegal) state_nxt = EMIT1;
      EMIT1:   if (mem_ready) state_nxt = need2 ? EMIT2 : IDLE;
      EMIT2:   if (mem_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_req   <= '0;
      need2     <= 1'b0;
      mem_wdata <= '0;
      addr      <= BASE;
      wrapped   <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= accept && bld_illegal;
      if (accept && !bld_illegal) begin
        lat_req   <= in_req;
        mem_wdata <= bld_word;
        need2     <= bld_second;
      end
      if (state == EMIT1 && mem_ready && need2)
        mem_wdata <= bld_word;
      // Clear wins over the increment; it can only occur in IDLE where no write completes
      if (state == IDLE && addr_clr)
        addr <= BASE;
      else if (wr_done) begin
        addr <= addr + ADDR_W'(1);
        if (&addr) wrapped <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Table-driven bench for instr_encoder with a write scoreboard plus
// hand sequences for stall, LI, illegal op, wrap, addr_clr and mid-write reset.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [4:0]  req_op, req_rs, req_rt, req_rd, req_shamt;
  logic [31:0] req_imm;
  logic [25:0] req_target;
  logic        addr_clr, mem_we, mem_ready;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        err, wrapped;

  instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_shamt(req_shamt), .req_imm(req_imm), .req_target(req_target),
    .addr_clr(addr_clr), .mem_we(mem_we), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .err(err), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
  } exp_t;

  typedef struct {
    logic [4:0]  op, rs, rt, rd, sh;
    logic [31:0] imm;
    logic [25:0] tgt;
    int          n;
    logic [31:0] w0, w1;
  } vec_t;

  exp_t       q[$];
  logic [9:0] exp_addr;
  int         nvec = 0;
  int         nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard: every completed write must match the oldest expected word
  always @(negedge clk) begin
    if (rst === 1'b0 && mem_we === 1'b1 && mem_ready === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_write", mem_wdata, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.a));
        chk("wr_data", mem_wdata, e.d);
      end
    end
  end

  task automatic wait_ready();
    int k = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (req_ready !== 1'b1) chk("ready_timeout", 32'(req_ready), 32'd1);
  endtask

  task automatic push(input logic [31:0] w);
    exp_t e;
    e.a = exp_addr;
    e.d = w;
    q.push_back(e);
    exp_addr = exp_addr + 10'd1;
  endtask

  task automatic send(input vec_t v);
    wait_ready();
    req_op = v.op; req_rs = v.rs; req_rt = v.rt; req_rd = v.rd; req_shamt = v.sh;
    req_imm = v.imm; req_target = v.tgt;
    req_valid = 1'b1;
    if (v.n > 0) push(v.w0);
    if (v.n > 1) push(v.w1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((q.size() != 0 || req_ready !== 1'b1) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("drain_left", 32'(q.size()), 32'd0);
  endtask

  function automatic vec_t mk(input int op, input int rs, input int rt, input int rd,
                              input int sh, input logic [31:0] imm, input logic [25:0] tgt,
                              input int n, input logic [31:0] w0, input logic [31:0] w1);
    vec_t v;
    v.op = 5'(op); v.rs = 5'(rs); v.rt = 5'(rt); v.rd = 5'(rd); v.sh = 5'(sh);
    v.imm = imm; v.tgt = tgt; v.n = n; v.w0 = w0; v.w1 = w1;
    return v;
  endfunction

  vec_t tbl[15];
  vec_t v;
  logic [9:0]  a0;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // op codes: ADD0 SUB1 SLT6 SLL7 JR8 JALR9 LW10 SW11 ORI14 BEQ17 LUI19 J20 JAL21 ERET22 NOP23 LI24
    tbl[0]  = mk(0,  1, 2, 3, 0, 32'h0, 26'h0, 1, 32'h0022_1820, 32'h0);
    tbl[1]  = mk(1,  4, 5, 6, 0, 32'h0, 26'h0, 1, 32'h0085_3022, 32'h0);
    tbl[2]  = mk(7,  7, 9, 10, 4, 32'h0, 26'h0, 1, 32'h0009_5100, 32'h0);
    tbl[3]  = mk(8, 31, 3, 4, 0, 32'h0, 26'h0, 1, 32'h03E0_0008, 32'h0);
    tbl[4]  = mk(9,  2, 0, 31, 0, 32'h0, 26'h0, 1, 32'h0040_F809, 32'h0);
    tbl[5]  = mk(10, 29, 8, 0, 0, 32'hABCD_FFFC, 26'h0, 1, 32'h8FA8_FFFC, 32'h0);
    tbl[6]  = mk(17, 1, 2, 0, 0, 32'h0000_0003, 26'h0, 1, 32'h1022_0003, 32'h0);
    tbl[7]  = mk(19, 5, 7, 0, 0, 32'h0000_1234, 26'h0, 1, 32'h3C07_1234, 32'h0);
    tbl[8]  = mk(21, 0, 0, 0, 0, 32'h0, 26'h3FF_FFFF, 1, 32'h0FFF_FFFF, 32'h0);
    tbl[9]  = mk(22, 3, 3, 3, 3, 32'h0, 26'h0, 1, 32'h4200_0018, 32'h0);
    tbl[10] = mk(23, 0, 0, 0, 0, 32'h0, 26'h0, 1, 32'h0000_0000, 32'h0);
    tbl[11] = mk(24, 0, 8, 0, 0, 32'h0000_0042, 26'h0, 1, 32'h3408_0042, 32'h0);
    tbl[12] = mk(24, 0, 8, 0, 0, 32'h1234_5678, 26'h0, 2, 32'h3C08_1234, 32'h3508_5678);
    tbl[13] = mk(6,  1, 2, 3, 0, 32'h0, 26'h0, 1, 32'h0022_182A, 32'h0);
    tbl[14] = mk(14, 3, 4, 0, 0, 32'h0000_8000, 26'h0, 1, 32'h3464_8000, 32'h0);

    rst = 1'b1; req_valid = 1'b0; addr_clr = 1'b0; mem_ready = 1'b1;
    req_op = '0; req_rs = '0; req_rt = '0; req_rd = '0; req_shamt = '0;
    req_imm = '0; req_target = '0;
    exp_addr = 10'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wrapped", 32'(wrapped), 32'd0);

    // first request: write appears one cycle after acceptance
    send(tbl[0]);
    @(negedge clk);
    chk("lat_we", 32'(mem_we), 32'd1);
    for (int i = 1; i < 15; i++) send(tbl[i]);
    drain();

    // two-word LI holds req_ready low for two cycles
    send(tbl[12]);
    @(negedge clk); chk("li_ready_c1", 32'(req_ready), 32'd0);
    @(negedge clk); chk("li_ready_c2", 32'(req_ready), 32'd0);
    @(negedge clk); chk("li_ready_c3", 32'(req_ready), 32'd1);
    drain();

    // SW under back-pressure; addr_clr during EMIT must be ignored
    mem_ready = 1'b0;
    a0 = exp_addr;
    send(mk(11, 29, 5, 0, 0, 32'h0000_0004, 26'h0, 1, 32'hAFA5_0004, 32'h0));
    addr_clr = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_we", 32'(mem_we), 32'd1);
      chk("stall_addr", 32'(mem_addr), 32'(a0));
      chk("stall_data", mem_wdata, 32'hAFA5_0004);
    end
    @(posedge clk);
    #1 mem_ready = 1'b1; addr_clr = 1'b0;
    drain();

    // illegal ops: err pulse, no write, address unchanged
    for (int k = 0; k < 2; k++) begin
      a0 = exp_addr;
      v = mk((k == 0) ? 25 : 31, 1, 1, 1, 0, 32'h0, 26'h0, 0, 32'h0, 32'h0);
      send(v);
      @(negedge clk);
      chk("ill_err", 32'(err), 32'd1);
      chk("ill_we", 32'(mem_we), 32'd0);
      chk("ill_addr", 32'(mem_addr), 32'(a0));
      @(negedge clk);
      chk("ill_err_pulse", 32'(err), 32'd0);
    end

    // standalone addr_clr in IDLE, then wrap with 2^10+1 NOPs
    @(posedge clk); #1 addr_clr = 1'b1;
    @(posedge clk); #1 addr_clr = 1'b0;
    exp_addr = 10'd0;
    @(negedge clk);
    chk("clr_addr", 32'(mem_addr), 32'd0);
    chk("pre_wrap", 32'(wrapped), 32'd0);
    for (int i = 0; i < 1025; i++) send(tbl[10]);
    drain();
    chk("wrapped", 32'(wrapped), 32'd1);
    chk("post_wrap_addr", 32'(mem_addr), 32'd1);

    // addr_clr coinciding with acceptance: word lands at BASE
    addr_clr = 1'b1;
    exp_addr = 10'd0;
    send(mk(20, 0, 0, 0, 0, 32'h0, 26'h000_0100, 1, 32'h0800_0100, 32'h0));
    addr_clr = 1'b0;
    drain();
    chk("wrapped_sticky", 32'(wrapped), 32'd1);

    // reset during EMIT2 of LI aborts the tail word
    send(tbl[12]);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    exp_addr = 10'd0;
    @(negedge clk);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_we", 32'(mem_we), 32'd0);
    chk("abort_addr", 32'(mem_addr), 32'd0);
    chk("abort_wdata", mem_wdata, 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_wrapped", 32'(wrapped), 32'd0);

    send(tbl[0]);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
